// File: rtl/dense_layer_scheduler_pkg.sv
// Shared types and default sizes for the dense-layer column scheduler.
package dense_sched_pkg;

    localparam int unsigned DEF_WIDTH      = 16;
    localparam int unsigned DEF_INPUT_SIZE = 128;
    localparam int unsigned DEF_NUM_OUT    = 16;
    localparam int unsigned DEF_TREE_LAT   = 7;
    localparam int unsigned DEF_COL_W      = $clog2(DEF_NUM_OUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    // Bit layout {vld, col} is also used for the flat tag vectors in the top.
    typedef struct packed {
        logic                 vld;
        logic [DEF_COL_W-1:0] col;
    } tag_t;

endpackage

// File: rtl/dense_layer_scheduler_issue_tag_delay.sv
// Delay line matching the engine latency; carries {vld, col} tags from issue to capture.
module issue_tag_delay
    import dense_sched_pkg::*;
#(
    parameter int unsigned TREE_LAT = DEF_TREE_LAT,
    parameter int unsigned TAG_W    = DEF_COL_W + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [TAG_W-1:0] i_tag,
    output logic [TAG_W-1:0] o_tag
);

    if (TREE_LAT == 0) begin : g_pass
        // Zero latency: the engine answers in the issue cycle, so no storage.
        assign o_tag = i_tag;
    end else begin : g_shift
        logic [TAG_W-1:0] r_sr [TREE_LAT];

        // Shift tags one stage per cycle; reset invalidates everything in flight.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                for (int i = 0; i < int'(TREE_LAT); i++) begin
                    r_sr[i] <= '0;
                end
            end else begin
                r_sr[0] <= i_tag;
                for (int i = 1; i < int'(TREE_LAT); i++) begin
                    r_sr[i] <= r_sr[i-1];
                end
            end
        end

        assign o_tag = r_sr[TREE_LAT-1];
    end

endmodule

// File: rtl/dense_layer_scheduler.sv
// Time-multiplexes one dense-column engine over all output neurons of a layer.
module dense_layer_scheduler
    import dense_sched_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned INPUT_SIZE = DEF_INPUT_SIZE,
    parameter int unsigned NUM_OUT    = DEF_NUM_OUT,
    parameter int unsigned TREE_LAT   = DEF_TREE_LAT
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_in_valid,
    output logic                                o_in_ready,
    input  logic signed [WIDTH*INPUT_SIZE-1:0]  i_in_data,
    output logic signed [WIDTH*INPUT_SIZE-1:0]  o_eng_data,
    output logic [$clog2(NUM_OUT)-1:0]          o_eng_col,
    output logic                                o_eng_issue,
    output logic                                o_eng_clear,
    input  logic signed [WIDTH-1:0]             i_eng_result,
    output logic signed [WIDTH*NUM_OUT-1:0]     o_out_data,
    output logic                                o_out_valid,
    input  logic                                i_out_ready,
    output logic                                o_busy
);

    localparam int unsigned COL_W = $clog2(NUM_OUT);
    localparam int unsigned TAG_W = COL_W + 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_OUT - 1);

    state_t r_state, w_state_nxt;
    logic [COL_W-1:0] r_cnt, w_cnt_nxt;
    logic signed [WIDTH*INPUT_SIZE-1:0] r_eng_data;
    logic signed [WIDTH*NUM_OUT-1:0] r_out_data;
    logic w_accept;
    logic w_issue;
    logic [TAG_W-1:0] w_tag_in, w_tag_out;
    logic w_tag_vld;
    logic [COL_W-1:0] w_tag_col;

    assign w_issue  = (r_state == ISSUE);
    assign w_accept = (r_state == IDLE) && i_in_valid;
    assign w_tag_in = {w_issue, r_cnt};
    assign w_tag_vld = w_tag_out[TAG_W-1];
    assign w_tag_col = w_tag_out[COL_W-1:0];

    issue_tag_delay #(
        .TREE_LAT (TREE_LAT),
        .TAG_W    (TAG_W)
    ) u_tag_delay (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_tag   (w_tag_in),
        .o_tag   (w_tag_out)
    );

    // State and issue-counter registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: accept, issue all columns, wait for the last result, hand off.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (i_in_valid) begin
                    w_state_nxt = ISSUE;
                    w_cnt_nxt   = '0;
                end
            end
            ISSUE: begin
                if (r_cnt == LAST_COL) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (TREE_LAT == 0) ? DONE : DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt + COL_W'(1);
                end
            end
            DRAIN: begin
                if (w_tag_vld && (w_tag_col == LAST_COL)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (i_out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Input vector held stable for the engine between accepts.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_eng_data <= '0;
        end else if (w_accept) begin
            r_eng_data <= i_in_data;
        end
    end

    // Capture the engine result into the slot named by the returning tag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_out_data <= '0;
        end else if (w_tag_vld) begin
            for (int k = 0; k < int'(NUM_OUT); k++) begin
                if (w_tag_col == COL_W'(k)) begin
                    r_out_data[k*WIDTH +: WIDTH] <= i_eng_result;
                end
            end
        end
    end

    assign o_in_ready  = (r_state == IDLE);
    assign o_eng_clear = (r_state == IDLE);
    assign o_eng_issue = w_issue;
    assign o_eng_col   = r_cnt;
    assign o_eng_data  = r_eng_data;
    assign o_out_data  = r_out_data;
    assign o_out_valid = (r_state == DONE);
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_dense_layer_scheduler.sv
// Directed and soak checks of dense_layer_scheduler against a stub column engine.
module tb_dense_layer_scheduler;

    localparam int W   = 16;
    localparam int IS  = 128;
    localparam int NO  = 16;
    localparam int LAT = 7;
    localparam int VW  = W * IS;
    localparam int OW  = W * NO;

    logic          clk = 1'b0;
    logic          rst;

    logic          in_valid, in_ready, eng_issue, eng_clear, out_valid, out_ready, busy;
    logic [VW-1:0] in_data, eng_data;
    logic [3:0]    eng_col;
    logic [W-1:0]  eng_result;
    logic [OW-1:0] out_data;

    logic          in_valid0, in_ready0, eng_issue0, eng_clear0, out_valid0, out_ready0, busy0;
    logic [VW-1:0] in_data0, eng_data0;
    logic [3:0]    eng_col0;
    logic [W-1:0]  eng_result0;
    logic [OW-1:0] out_data0;

    logic [W-1:0]  pipe [LAT];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dense_layer_scheduler #(
        .WIDTH(W), .INPUT_SIZE(IS), .NUM_OUT(NO), .TREE_LAT(LAT)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_data(in_data), .o_eng_data(eng_data), .o_eng_col(eng_col),
        .o_eng_issue(eng_issue), .o_eng_clear(eng_clear), .i_eng_result(eng_result),
        .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready), .o_busy(busy)
    );

    dense_layer_scheduler #(
        .WIDTH(W), .INPUT_SIZE(IS), .NUM_OUT(NO), .TREE_LAT(0)
    ) dut_lat0 (
        .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid0), .o_in_ready(in_ready0),
        .i_in_data(in_data0), .o_eng_data(eng_data0), .o_eng_col(eng_col0),
        .o_eng_issue(eng_issue0), .o_eng_clear(eng_clear0), .i_eng_result(eng_result0),
        .o_out_data(out_data0), .o_out_valid(out_valid0), .i_out_ready(out_ready0),
        .o_busy(busy0)
    );

    // Stub engine: result = first input word + 3*col + 1, junk when nothing was issued.
    function automatic logic [W-1:0] stub_val(input logic [W-1:0] seed, input logic [3:0] col);
        return seed + W'(3 * int'(col) + 1);
    endfunction

    always @(posedge clk) begin
        pipe[0] <= eng_issue ? stub_val(eng_data[W-1:0], eng_col) : 16'h7BAD;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign eng_result  = pipe[LAT-1];
    assign eng_result0 = eng_issue0 ? stub_val(eng_data0[W-1:0], eng_col0) : 16'h7BAD;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] exp_out(input logic [W-1:0] seed);
        logic [OW-1:0] r;
        r = '0;
        for (int k = 0; k < NO; k++) r[k*W +: W] = seed + W'(3 * k + 1);
        return r;
    endfunction

    function automatic logic [VW-1:0] mk_vec(input logic [W-1:0] seed);
        logic [VW-1:0] v;
        v = '0;
        v[W-1:0] = seed;
        for (int i = 1; i < IS; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    // Bounded wait for out_valid; cyc tracks the cycle number relative to the accept edge.
    task automatic wait_valid(input int start, output int cyc);
        cyc = start;
        while (!out_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        check("out_valid_reached", out_valid, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [VW-1:0] va, vb, vc, vd, ve, vf, vg;
        logic [W-1:0]  seed;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b1;
        tick(); tick();

        // Reset values
        check("rst_in_ready", in_ready, 1);
        check("rst_eng_clear", eng_clear, 1);
        check("rst_eng_issue", eng_issue, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_eng_col", eng_col, 0);
        check("rst_out_data_zero", out_data == '0, 1);
        check("rst_eng_data_zero", eng_data == '0, 1);
        rst = 1'b0;
        tick();

        // Single vector, results 3k+1
        va = mk_vec(16'd0);
        in_data = va; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_issue", eng_issue, 1);
        check("t1_col0", eng_col, 0);
        check("t1_eng_data", eng_data == va, 1);
        check("t1_in_ready_low", in_ready, 0);
        check("t1_busy", busy, 1);
        check("t1_eng_clear_low", eng_clear, 0);
        tick();
        check("t1_col1", eng_col, 1);
        wait_valid(2, cyc);
        check("t1_valid_cycle", cyc, 24);
        for (int k = 0; k < NO; k++)
            check($sformatf("t1_out%0d", k), out_data[k*W +: W], 3 * k + 1);
        tick();
        check("t1_valid_one_cycle", out_valid, 0);
        check("t1_in_ready_cycle25", in_ready, 1);

        // Backpressure for 50 cycles with ignored in_valid pulses
        out_ready = 1'b0;
        vb = mk_vec(16'd100);
        in_data = vb; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(1, cyc);
        check("t2_valid_cycle", cyc, 24);
        for (int i = 0; i < 50; i++) begin
            in_valid = (i % 5 == 0);
            in_data  = mk_vec(16'd9);
            tick();
            check("t2_hold_valid", out_valid, 1);
            check("t2_hold_data", out_data == exp_out(16'd100), 1);
            check("t2_eng_data", eng_data == vb, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t2_release_idle", in_ready, 1);
        check("t2_release_valid", out_valid, 0);
        check("t2_release_busy", busy, 0);

        // Back-to-back with in_valid held high
        vc = mk_vec(16'd200);
        vd = mk_vec(16'd300);
        in_data = vc; in_valid = 1'b1;
        tick();
        in_data = vd;
        for (int c = 1; c <= 25; c++) begin
            check($sformatf("t3_eng_data_c%0d", c), eng_data == vc, 1);
            check($sformatf("t3_valid_c%0d", c), out_valid, (c == 24));
            if (c == 24) check("t3_data1", out_data == exp_out(16'd200), 1);
            if (c == 25) check("t3_accept_ready", in_ready, 1);
            if (c < 25) tick();
        end
        tick();
        in_valid = 1'b0;
        check("t3_eng_data2", eng_data == vd, 1);
        wait_valid(1, cyc);
        check("t3_valid_cycle2", cyc, 24);
        check("t3_data2", out_data == exp_out(16'd300), 1);
        tick();

        // Reset in cycle 10 of a run, held 2 cycles
        ve = mk_vec(16'd500);
        in_data = ve; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        rst = 1'b1;
        #1;
        check("t4_in_ready", in_ready, 1);
        check("t4_eng_clear", eng_clear, 1);
        check("t4_eng_issue", eng_issue, 0);
        check("t4_busy", busy, 0);
        check("t4_out_valid", out_valid, 0);
        check("t4_eng_col", eng_col, 0);
        check("t4_out_data_zero", out_data == '0, 1);
        check("t4_eng_data_zero", eng_data == '0, 1);
        tick(); tick();
        rst = 1'b0;
        vf = mk_vec(16'd1000);
        in_data = vf; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("t4_no_stale_c%0d", c), out_data == '0, 1);
            tick();
        end
        check("t4_first_capture", out_data[W-1:0], 16'd1001);
        wait_valid(9, cyc);
        check("t4_valid_cycle", cyc, 24);
        check("t4_data", out_data == exp_out(16'd1000), 1);
        tick();

        // Zero-latency build
        vg = mk_vec(16'd40);
        in_data0 = vg; in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        check("t5_issue", eng_issue0, 1);
        check("t5_pre_capture", out_data0[W-1:0], 0);
        tick();
        check("t5_capture_col0", out_data0[W-1:0], 16'd41);
        cyc = 2;
        while (!out_valid0 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("t5_valid_reached", out_valid0, 1);
        check("t5_valid_cycle", cyc, 17);
        check("t5_data", out_data0 == exp_out(16'd40), 1);
        tick();
        check("t5_idle", in_ready0, 1);

        // Soak: random vectors, random output stalls, occasional mid-run resets
        out_ready = 1'b0;
        for (int v = 0; v < 1000; v++) begin
            seed = W'($urandom);
            in_data = mk_vec(seed);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check("soak_accept", busy, 1);
            if ($urandom_range(0, 15) == 0) begin
                repeat ($urandom_range(0, 20)) tick();
                rst = 1'b1;
                #1;
                check("soak_rst_data", out_data == '0, 1);
                tick();
                rst = 1'b0;
            end else begin
                cyc = 1;
                while (!out_valid && cyc < 100) begin
                    tick();
                    cyc++;
                end
                check("soak_latency", cyc, 24);
                repeat ($urandom_range(0, 3)) tick();
                check("soak_data", out_data == exp_out(seed), 1);
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
                check("soak_idle", in_ready, 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dense_layer_scheduler.md
# dense_layer_scheduler

Sequences one shared dense-column engine (multiply by package weights, adder tree, bias, ReLU) across all output neurons of a dense layer. It accepts one input activation vector through a valid/ready handshake and holds it stable for the engine. It issues one column index per cycle, pipelined into the engine, and captures each result after the fixed tree latency into an output buffer. It then presents the full output vector with valid/ready. It sits between the flatten/conv stage and the next layer, replacing NUM_OUT parallel column instances with one.

## Interface
- WIDTH, 16: fixed-point word width (Q5.10 format).
- INPUT_SIZE, 128: input vector length.
- NUM_OUT, 16: number of output neurons (columns).
- TREE_LAT, 7: engine latency in cycles from issue to result. Range 0..15.
- clk  in  1: clock; all logic rising-edge.
- reset  in  1: active-high reset. Asynchronous assert; assertion does not depend on clk.
- in_valid  in  1: input vector valid.
- in_ready  out  1: scheduler can accept a vector. Reset value 1.
- in_data  in  WIDTH×INPUT_SIZE signed: input vector.
- eng_data  out  WIDTH×INPUT_SIZE signed: latched vector to the engine. Reset value all 0.
- eng_col  out  $clog2(NUM_OUT): column index for this cycle. Reset value 0.
- eng_issue  out  1: column issue strobe. Reset value 0.
- eng_clear  out  1: engine pipeline clear, drives the engine's tree reset. Reset value 1.
- eng_result  in  WIDTH signed: engine output, already ReLU'd.
- out_data  out  WIDTH×NUM_OUT signed: result vector; index k holds column k. Reset value all 0.
- out_valid  out  1: out_data complete. Reset value 0.
- out_ready  in  1: consumer accepts out_data.
- busy  out  1: high in every state except IDLE. Reset value 0.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE. Reset enters IDLE.
- IDLE
  - in_ready=1 and eng_clear=1.
  - On in_valid&&in_ready: latch in_data into eng_data, clear issue counter, go to ISSUE.
- ISSUE
  - eng_issue=1 with eng_col=0,1,…,NUM_OUT-1 on consecutive cycles.
  - A tag (valid bit plus column index) enters a TREE_LAT-deep delay line each issue cycle.
  - After the cycle with col NUM_OUT-1: go to DRAIN, or to DONE if TREE_LAT=0.
- Capture
  - When the delay-line output tag is valid, eng_result is written to out_data[tag.col] at that edge.
  - With TREE_LAT=0, capture happens in the issue cycle itself.
- DRAIN
  - eng_issue=0.
  - Go to DONE on the edge that captures column NUM_OUT-1.
- DONE
  - out_valid=1; out_data is stable and no longer written.
  - On out_ready: go to IDLE and drop out_valid.
- eng_data stays constant from the accept edge until the next accept.
- in_ready=0 in ISSUE, DRAIN and DONE. The block never overlaps two vectors.
- out_data keeps its last vector until it is overwritten by the next run.
- Width rule: results pass through unmodified. The scheduler does no arithmetic except counters.

## Timing
- Accept edge = cycle 0.
- eng_issue is high in cycles 1..NUM_OUT; col k is issued in cycle k+1.
- Result for col k is sampled at the end of cycle k+1+TREE_LAT.
- out_valid rises in cycle NUM_OUT+TREE_LAT+1 (24 with defaults).
- If out_ready is already high: DONE lasts 1 cycle, IDLE/in_ready in cycle NUM_OUT+TREE_LAT+2. Next accept is possible then.
- Throughput: one vector per NUM_OUT+TREE_LAT+2 cycles best case.
- out_ready held low: DONE persists indefinitely and out_data holds.
- in_valid during busy: ignored, no latch.
- Reset mid-run:
  - Return to IDLE immediately.
  - Clear every delay-line tag, so in-flight results are never captured.
  - out_valid=0 and out_data=0.

## Structure
- Package dense_sched_pkg holds:
  - state enum state_t {IDLE, ISSUE, DRAIN, DONE};
  - tag struct {logic vld; logic [$clog2(NUM_OUT)-1:0] col;};
  - default WIDTH, INPUT_SIZE, NUM_OUT, TREE_LAT constants.
- Sub-module issue_tag_delay:
  - parameterised depth TREE_LAT shift register of tags;
  - asynchronous reset to invalid;
  - depth 0 passes the tag through combinationally.
- Weights and biases remain in data16_10 and are indexed by the engine using eng_col. The scheduler does not read them.

## Test plan
- Single vector, stub engine result = col*3+1, TREE_LAT=7, out_ready=1:
  - out_valid in cycle 24 for exactly 1 cycle;
  - out_data[k]=3k+1 for k=0..15;
  - in_ready back high in cycle 25.
- Backpressure, out_ready held 0 for 50 cycles:
  - out_valid stays 1 and out_data is unchanged;
  - in_valid pulses during this window are ignored (eng_data unchanged);
  - releasing out_ready returns the block to IDLE on the next edge.
- Back-to-back, two vectors with in_valid always high:
  - the second accept occurs in cycle 25;
  - eng_data changes only at the accept edges;
  - each result set matches its own vector.
- Reset asserted in cycle 10 (mid-ISSUE) for 2 cycles:
  - outputs at reset values immediately;
  - stale eng_result values never appear in the next run's out_data.
- TREE_LAT=0 build:
  - captures occur in issue cycles 1..16;
  - out_valid in cycle 17.
- Random stall and reset soak, 1000 vectors, compared against a scoreboard model:
  - no lost, duplicated or misindexed columns.
